// File: rtl/bip_pkg.sv
// Shared encodings for the BIP accumulator datapath: opcodes, source selects,
// flag bit positions and the control FSM state type.
package bip_pkg;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_SHL1 = 3'd5;
  localparam logic [2:0] OP_SRA1 = 3'd6;
  localparam logic [2:0] OP_MUL  = 3'd7;

  localparam logic [1:0] SELA_DM   = 2'd0;
  localparam logic [1:0] SELA_IMM  = 2'd1;
  localparam logic [1:0] SELA_ALU  = 2'd2;
  localparam logic [1:0] SELA_NONE = 2'd3;

  localparam logic SELB_DM  = 1'b0;
  localparam logic SELB_IMM = 1'b1;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/bip_mul_seq.sv
// Iterative shift-add multiplier. Produces the low DATA_W bits of a_i * b_i,
// which is the same bit pattern for signed and unsigned operands. One
// multiplier bit is consumed per cycle; done_o marks the final iteration and
// product_o already includes that iteration so the caller can capture it on
// the same edge.
module bip_mul_seq
  import bip_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] product_o
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic              busy_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] mcand_q;
  logic [DATA_W-1:0] mplier_q;
  logic [DATA_W-1:0] prod_q;
  logic [DATA_W-1:0] prod_d;

  // Partial-product accumulation for the current multiplier bit.
  always_comb begin
    prod_d = prod_q;
    if (mplier_q[0]) begin
      prod_d = prod_q + mcand_q;
    end
  end

  // Operand latch on start, then one shift-add step per cycle until the count expires.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
    end else if (busy_q) begin
      prod_q   <= prod_d;
      mcand_q  <= {mcand_q[DATA_W-2:0], 1'b0};
      mplier_q <= {1'b0, mplier_q[DATA_W-1:1]};
      cnt_q    <= cnt_q - 1'b1;
      if (cnt_q == CNT_W'(1)) begin
        busy_q <= 1'b0;
      end
    end else if (start_i) begin
      busy_q   <= 1'b1;
      cnt_q    <= CNT_W'(DATA_W);
      mcand_q  <= a_i;
      mplier_q <= b_i;
      prod_q   <= '0;
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = busy_q && (cnt_q == CNT_W'(1));
  assign product_o = prod_d;

endmodule

// File: rtl/bip_datapath_param.sv
// BIP accumulator datapath: operand sign extension, B-operand mux, eight-op
// ALU, accumulator with registered Z/N/C/V flags, and a small FSM that parks
// the datapath while the sequential multiplier runs (commands are dropped
// while BUSY is high).
module bip_datapath_param
  import bip_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int OPERAND_W = 11
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [OPERAND_W-1:0] OPERAND_IN,
  input  logic [DATA_W-1:0]    DM_IN,
  input  logic [1:0]           SEL_A,
  input  logic                 SEL_B,
  input  logic                 WR_ACC,
  input  logic [2:0]           OP,
  output logic [DATA_W-1:0]    ACC,
  output logic [OPERAND_W-1:0] OPERAND_OUT,
  output logic [3:0]           FLAGS,
  output logic                 BUSY
);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [3:0]          flags_q, flags_d;

  logic signed [OPERAND_W-1:0] opnd_s;
  logic signed [DATA_W-1:0]    imm_ext;
  logic signed [DATA_W-1:0]    acc_s;
  logic [DATA_W-1:0]           b_op;
  logic [DATA_W:0]             ext;
  logic [DATA_W-1:0]           alu_res;
  logic                        alu_c;
  logic                        alu_v;
  logic [DATA_W-1:0]           wr_val;

  logic                        cmd_ok;
  logic                        wr_req;
  logic                        mul_start;
  logic                        mul_busy;
  logic                        mul_done;
  logic [DATA_W-1:0]           mul_prod;

  assign opnd_s  = OPERAND_IN;
  assign imm_ext = DATA_W'(opnd_s);
  assign acc_s   = acc_q;
  assign b_op    = (SEL_B == SELB_IMM) ? imm_ext : DM_IN;

  // Command acceptance: only in IDLE with the multiplier quiet.
  assign cmd_ok    = (state_q == ST_IDLE) && !mul_busy;
  assign wr_req    = cmd_ok && WR_ACC && (SEL_A != SELA_NONE);
  assign mul_start = wr_req && (SEL_A == SELA_ALU) && (OP == OP_MUL);

  // Single-cycle ALU with carry/borrow and signed-overflow detection.
  always_comb begin
    ext     = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (OP)
      OP_ADD: begin
        ext     = {1'b0, acc_q} + {1'b0, b_op};
        alu_res = ext[DATA_W-1:0];
        alu_c   = ext[DATA_W];
        alu_v   = (acc_q[DATA_W-1] == b_op[DATA_W-1]) &&
                  (alu_res[DATA_W-1] != acc_q[DATA_W-1]);
      end
      OP_SUB: begin
        ext     = {1'b0, acc_q} - {1'b0, b_op};
        alu_res = ext[DATA_W-1:0];
        alu_c   = ~ext[DATA_W];
        alu_v   = (acc_q[DATA_W-1] != b_op[DATA_W-1]) &&
                  (alu_res[DATA_W-1] != acc_q[DATA_W-1]);
      end
      OP_AND:  alu_res = acc_q & b_op;
      OP_OR:   alu_res = acc_q | b_op;
      OP_XOR:  alu_res = acc_q ^ b_op;
      OP_SHL1: begin
        alu_res = {acc_q[DATA_W-2:0], 1'b0};
        alu_c   = acc_q[DATA_W-1];
      end
      OP_SRA1: begin
        alu_res = acc_s >>> 1;
        alu_c   = acc_q[0];
      end
      default: alu_res = '0;
    endcase
  end

  // Accumulator source mux.
  always_comb begin
    case (SEL_A)
      SELA_DM:  wr_val = DM_IN;
      SELA_IMM: wr_val = imm_ext;
      default:  wr_val = alu_res;
    endcase
  end

  // Next-state logic for FSM, accumulator and flags.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    flags_d = flags_q;
    if (state_q == ST_MUL) begin
      if (mul_done) begin
        state_d         = ST_IDLE;
        acc_d           = mul_prod;
        flags_d[FLAG_Z] = (mul_prod == '0);
        flags_d[FLAG_N] = mul_prod[DATA_W-1];
        flags_d[FLAG_C] = 1'b0;
        flags_d[FLAG_V] = 1'b0;
      end
    end else if (mul_start) begin
      state_d = ST_MUL;
    end else if (wr_req) begin
      acc_d           = wr_val;
      flags_d[FLAG_Z] = (wr_val == '0);
      flags_d[FLAG_N] = wr_val[DATA_W-1];
      if (SEL_A == SELA_ALU) begin
        flags_d[FLAG_C] = alu_c;
        flags_d[FLAG_V] = alu_v;
      end
    end
  end

  // State registers; reset aborts any multiply in flight.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      flags_q <= flags_d;
    end
  end

  bip_mul_seq #(
    .DATA_W(DATA_W)
  ) u_mul (
    .clk_i     (CLK),
    .rst_i     (RESET),
    .start_i   (mul_start),
    .a_i       (acc_q),
    .b_i       (b_op),
    .busy_o    (mul_busy),
    .done_o    (mul_done),
    .product_o (mul_prod)
  );

  assign ACC         = acc_q;
  assign FLAGS       = flags_q;
  assign BUSY        = (state_q == ST_MUL);
  assign OPERAND_OUT = OPERAND_IN;

endmodule
